// File: rtl/core_debug_host_bridge_pkg.sv
// Shared constants for the host-side debug bridge:
// frame headers, command/target codes, states, frame lengths.
package core_debug_host_bridge_pkg;

    localparam logic [3:0] CMD_HDR  = 4'hA;
    localparam logic [3:0] RESP_HDR = 4'h5;

    localparam logic [3:0] DBG_READ_REG  = 4'h0;
    localparam logic [3:0] DBG_WRITE_REG = 4'h1;
    localparam logic [3:0] DBG_GO        = 4'h8;
    localparam logic [3:0] DBG_INTGO     = 4'h9;
    localparam logic [3:0] DBG_STEP      = 4'hA;
    localparam logic [3:0] DBG_STOP      = 4'hF;

    localparam logic [7:0] REG_CPUIDR = 8'h40;

    localparam int CMD_LEN  = 6;
    localparam int RESP_LEN = 5;

    typedef enum logic [2:0] {
        ST_RX_HDR,
        ST_RX_BODY,
        ST_ISSUE,
        ST_WAIT_RESP,
        ST_TX
    } state_t;

endpackage

// File: rtl/core_debug_host_tx_ser.sv
// Response frame serializer: loads {status, data} and
// shifts out five bytes under the VALID/BUSY handshake.
module core_debug_host_tx_ser
    import core_debug_host_bridge_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [39:0] frame,
    input  logic        busy,
    output logic        valid,
    output logic [7:0]  data,
    output logic        last
);

    localparam logic [2:0] LAST_IDX = 3'(RESP_LEN - 1);

    logic [39:0] shift;
    logic [2:0]  idx;

    assign data = shift[39:32];
    assign last = valid && !busy && (idx == LAST_IDX);

    // Hold the current byte until it transfers, then advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift <= '0;
            idx   <= '0;
            valid <= 1'b0;
        end else if (load) begin
            shift <= frame;
            idx   <= '0;
            valid <= 1'b1;
        end else if (valid && !busy) begin
            if (idx == LAST_IDX) begin
                valid <= 1'b0;
                shift <= '0;
                idx   <= '0;
            end else begin
                shift <= {shift[31:0], 8'h00};
                idx   <= idx + 3'd1;
            end
        end
    end

endmodule

// File: rtl/core_debug_host_bridge.sv
// Host-side debug initiator: byte stream to command frame,
// REQ/BUSY issue, response wait with timeout, response out.
module core_debug_host_bridge
    import core_debug_host_bridge_pkg::*;
#(
    parameter int P_RESP_TIMEOUT = 1024,
    parameter int P_TIMEOUT_W    = 11
) (
    input  logic        iCLOCK,
    input  logic        iRESET_SYNC,
    input  logic        iRX_VALID,
    input  logic [7:0]  iRX_DATA,
    output logic        oRX_BUSY,
    output logic        oCMD_REQ,
    input  logic        iCMD_BUSY,
    output logic [3:0]  oCMD_COMMAND,
    output logic [7:0]  oCMD_TARGET,
    output logic [31:0] oCMD_DATA,
    input  logic        iRESP_VALID,
    input  logic        iRESP_ERROR,
    input  logic [31:0] iRESP_DATA,
    output logic        oTX_VALID,
    output logic [7:0]  oTX_DATA,
    input  logic        iTX_BUSY,
    output logic        oERR_FRAME,
    output logic        oIDLE
);

    localparam logic [P_TIMEOUT_W-1:0] TO_LAST =
        P_TIMEOUT_W'(P_RESP_TIMEOUT - 1);
    localparam logic [P_TIMEOUT_W-1:0] TO_MAX = '1;
    localparam logic [2:0] RX_LAST = 3'(CMD_LEN - 1);

    state_t                 state;
    logic [2:0]             idx;
    logic [P_TIMEOUT_W-1:0] tmo_cnt;
    logic [3:0]             cmd;
    logic [7:0]             target;
    logic [31:0]            data;
    logic                   rx_busy;
    logic                   cmd_req;
    logic                   err_frame;
    logic                   idle;

    logic        rx_accept;
    logic        cmd_accept;
    logic        tx_load;
    logic [39:0] tx_frame;
    logic        tx_last;

    assign rx_accept  = iRX_VALID && !rx_busy;
    assign cmd_accept = cmd_req && !iCMD_BUSY;

    assign oRX_BUSY     = rx_busy;
    assign oCMD_REQ     = cmd_req;
    assign oCMD_COMMAND = cmd;
    assign oCMD_TARGET  = target;
    assign oCMD_DATA    = data;
    assign oERR_FRAME   = err_frame;
    assign oIDLE        = idle;

    // Response capture: a real response beats a same-cycle timeout.
    always_comb begin
        tx_load  = 1'b0;
        tx_frame = '0;
        if (state == ST_WAIT_RESP) begin
            if (iRESP_VALID) begin
                tx_load  = 1'b1;
                tx_frame = {RESP_HDR, 2'b00, 1'b0, iRESP_ERROR,
                            iRESP_DATA};
            end else if (tmo_cnt == TO_LAST) begin
                tx_load  = 1'b1;
                tx_frame = {RESP_HDR, 2'b00, 1'b1, 1'b0, 32'h0};
            end
        end
    end

    // Main sequencer with registered handshake/status outputs.
    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            state     <= ST_RX_HDR;
            idx       <= '0;
            tmo_cnt   <= '0;
            cmd       <= '0;
            target    <= '0;
            data      <= '0;
            rx_busy   <= 1'b0;
            cmd_req   <= 1'b0;
            err_frame <= 1'b0;
            idle      <= 1'b1;
        end else begin
            err_frame <= 1'b0;
            unique case (state)
                ST_RX_HDR: begin
                    if (rx_accept) begin
                        if (iRX_DATA[7:4] == CMD_HDR) begin
                            cmd   <= iRX_DATA[3:0];
                            idx   <= 3'd1;
                            idle  <= 1'b0;
                            state <= ST_RX_BODY;
                        end else begin
                            err_frame <= 1'b1;
                        end
                    end
                end
                ST_RX_BODY: begin
                    if (rx_accept) begin
                        if (idx == 3'd1) begin
                            target <= iRX_DATA;
                        end else begin
                            data <= {data[23:0], iRX_DATA};
                        end
                        if (idx == RX_LAST) begin
                            idx     <= '0;
                            rx_busy <= 1'b1;
                            cmd_req <= 1'b1;
                            state   <= ST_ISSUE;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (cmd_accept) begin
                        cmd_req <= 1'b0;
                        tmo_cnt <= '0;
                        state   <= ST_WAIT_RESP;
                    end
                end
                ST_WAIT_RESP: begin
                    if (tx_load) begin
                        state <= ST_TX;
                    end else if (tmo_cnt != TO_MAX) begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                ST_TX: begin
                    if (tx_last) begin
                        rx_busy <= 1'b0;
                        idle    <= 1'b1;
                        state   <= ST_RX_HDR;
                    end
                end
                default: state <= ST_RX_HDR;
            endcase
        end
    end

    core_debug_host_tx_ser u_tx_ser (
        .clk   (iCLOCK),
        .rst   (iRESET_SYNC),
        .load  (tx_load),
        .frame (tx_frame),
        .busy  (iTX_BUSY),
        .valid (oTX_VALID),
        .data  (oTX_DATA),
        .last  (tx_last)
    );

endmodule

// File: tb/tb_core_debug_host_bridge.sv
// Directed bench for core_debug_host_bridge with a short
// response timeout; all checks go through chk().
module tb_core_debug_host_bridge;

    logic        clk;
    logic        rst;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_busy;
    logic        cmd_req;
    logic        cmd_busy;
    logic [3:0]  cmd_command;
    logic [7:0]  cmd_target;
    logic [31:0] cmd_data;
    logic        resp_valid;
    logic        resp_error;
    logic [31:0] resp_data;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic        err_frame;
    logic        idle;

    int n_checks = 0;
    int n_fail   = 0;

    core_debug_host_bridge #(
        .P_RESP_TIMEOUT (16),
        .P_TIMEOUT_W    (5)
    ) dut (
        .iCLOCK       (clk),
        .iRESET_SYNC  (rst),
        .iRX_VALID    (rx_valid),
        .iRX_DATA     (rx_data),
        .oRX_BUSY     (rx_busy),
        .oCMD_REQ     (cmd_req),
        .iCMD_BUSY    (cmd_busy),
        .oCMD_COMMAND (cmd_command),
        .oCMD_TARGET  (cmd_target),
        .oCMD_DATA    (cmd_data),
        .iRESP_VALID  (resp_valid),
        .iRESP_ERROR  (resp_error),
        .iRESP_DATA   (resp_data),
        .oTX_VALID    (tx_valid),
        .oTX_DATA     (tx_data),
        .iTX_BUSY     (tx_busy),
        .oERR_FRAME   (err_frame),
        .oIDLE        (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [39:0] got,
                       input logic [39:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int waitc;
        waitc = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        while (rx_busy && waitc < 100) begin
            tick();
            waitc++;
        end
        if (rx_busy) chk("rx_wait", 40'(rx_busy), 40'd0);
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic send_frame(input logic [47:0] f);
        for (int i = 0; i < 6; i++) send_byte(f[47 - 8*i -: 8]);
    endtask

    task automatic pulse_resp(input logic err, input logic [31:0] d);
        resp_valid = 1'b1;
        resp_error = err;
        resp_data  = d;
        tick();
        resp_valid = 1'b0;
        resp_error = 1'b0;
        resp_data  = '0;
    endtask

    // Entry: first cycle where B0 must already be presented.
    task automatic collect(input string tag, input logic [39:0] exp,
                           input bit toggle);
        int n;
        int cyc;
        logic [7:0] eb;
        n = 0;
        cyc = 0;
        chk({tag, "_b0_lat"}, 40'(tx_valid), 40'd1);
        while (n < 5 && cyc < 100) begin
            tx_busy = toggle ? ~cyc[0] : 1'b0;
            eb = exp[39 - 8*n -: 8];
            if (!tx_valid) begin
                chk({tag, "_valid"}, 40'(tx_valid), 40'd1);
                break;
            end
            if (!tx_busy) begin
                chk({tag, "_byte"}, 40'(tx_data), 40'(eb));
                n++;
            end else begin
                chk({tag, "_hold"}, 40'(tx_data), 40'(eb));
            end
            tick();
            cyc++;
        end
        tx_busy = 1'b0;
        chk({tag, "_count"}, 40'(n), 40'd5);
        chk({tag, "_end_valid"}, 40'(tx_valid), 40'd0);
        chk({tag, "_end_idle"}, 40'(idle), 40'd1);
    endtask

    initial begin
        rst        = 1'b1;
        rx_valid   = 1'b0;
        rx_data    = '0;
        cmd_busy   = 1'b0;
        resp_valid = 1'b0;
        resp_error = 1'b0;
        resp_data  = '0;
        tx_busy    = 1'b0;
        repeat (3) tick();

        chk("rst_rx_busy", 40'(rx_busy), 40'd0);
        chk("rst_req", 40'(cmd_req), 40'd0);
        chk("rst_fields", {cmd_command, cmd_target, cmd_data[27:0]},
            40'd0);
        chk("rst_tx", {31'd0, tx_valid, tx_data}, 40'd0);
        chk("rst_err", 40'(err_frame), 40'd0);
        chk("rst_idle", 40'(idle), 40'd1);
        rst = 1'b0;
        tick();

        // 1: READ_REG CPUIDR, response two cycles into wait
        send_frame(48'hA0_40_00_00_00_00);
        chk("t1_req", 40'(cmd_req), 40'd1);
        chk("t1_cmd", 40'(cmd_command), 40'h0);
        chk("t1_tgt", 40'(cmd_target), 40'h40);
        chk("t1_data", 40'(cmd_data), 40'h0);
        chk("t1_rxbusy", 40'(rx_busy), 40'd1);
        tick();
        chk("t1_req_drop", 40'(cmd_req), 40'd0);
        tick();
        pulse_resp(1'b0, 32'h1234_5678);
        collect("t1", 40'h50_1234_5678, 1'b0);

        // 2: STOP with debug block busy for 7 cycles
        cmd_busy = 1'b1;
        send_frame(48'hAF_00_00_00_00_00);
        for (int i = 0; i < 7; i++) begin
            chk("t2_req_hold", 40'(cmd_req), 40'd1);
            chk("t2_cmd_hold", 40'(cmd_command), 40'hF);
            chk("t2_fields", {cmd_target, cmd_data}, 40'd0);
            tick();
        end
        cmd_busy = 1'b0;
        chk("t2_req_8", 40'(cmd_req), 40'd1);
        tick();
        chk("t2_req_drop", 40'(cmd_req), 40'd0);
        pulse_resp(1'b0, 32'h0);
        collect("t2", 40'h50_0000_0000, 1'b0);

        // 3: WRITE_REG with no answer times out
        send_frame(48'hA1_05_DE_AD_BE_EF);
        chk("t3_cmd", 40'(cmd_command), 40'h1);
        chk("t3_data", 40'(cmd_data), 40'hDEAD_BEEF);
        tick();
        chk("t3_req_drop", 40'(cmd_req), 40'd0);
        for (int i = 1; i < 16; i++) begin
            chk("t3_no_tx_early", 40'(tx_valid), 40'd0);
            tick();
        end
        tick();
        collect("t3", 40'h52_0000_0000, 1'b0);

        // 4: response on the terminal timeout cycle wins
        send_frame(48'hA0_01_00_00_00_00);
        tick();
        for (int i = 1; i < 16; i++) tick();
        chk("t4_no_tx_early", 40'(tx_valid), 40'd0);
        pulse_resp(1'b1, 32'hCAFE_F00D);
        collect("t4", 40'h51_CAFE_F00D, 1'b0);

        // 5: bad headers dropped, then GO frame, TX throttled
        send_byte(8'h3C);
        chk("t5_err1", 40'(err_frame), 40'd1);
        chk("t5_idle1", 40'(idle), 40'd1);
        tick();
        chk("t5_err_low", 40'(err_frame), 40'd0);
        send_byte(8'h00);
        chk("t5_err2", 40'(err_frame), 40'd1);
        send_frame(48'hA8_00_00_00_00_00);
        chk("t5_req", 40'(cmd_req), 40'd1);
        chk("t5_cmd", 40'(cmd_command), 40'h8);
        chk("t5_err_quiet", 40'(err_frame), 40'd0);
        tick();
        pulse_resp(1'b0, 32'hA5C3_0F96);
        collect("t5", 40'h50_A5C3_0F96, 1'b1);

        // 6: reset while B2 is on the wire
        send_frame(48'hA0_02_00_00_00_00);
        tick();
        pulse_resp(1'b0, 32'h1122_3344);
        tick();
        tick();
        chk("t6_b2", 40'(tx_data), 40'h22);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_tx_off", 40'(tx_valid), 40'd0);
        chk("t6_idle", 40'(idle), 40'd1);
        chk("t6_rx_ready", 40'(rx_busy), 40'd0);
        tick();
        chk("t6_still_off", 40'(tx_valid), 40'd0);
        send_frame(48'hA9_07_01_02_03_04);
        chk("t6_cmd", 40'(cmd_command), 40'h9);
        chk("t6_tgt", 40'(cmd_target), 40'h07);
        chk("t6_data", 40'(cmd_data), 40'h0102_0304);
        tick();
        pulse_resp(1'b0, 32'h0BAD_C0DE);
        collect("t6", 40'h50_0BAD_C0DE, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/core_debug_host_bridge.md
Name: core_debug_host_bridge

Overview:
Host-side initiator for the core debug command/response interface. It assembles 6-byte command frames from a byte stream (debug UART RX or JTAG byte FIFO), issues each frame as one command on the debug CMD port using REQ/BUSY, and waits for RESP_VALID with a timeout. It then serializes a 5-byte response frame to a byte-stream transmitter. It sits between the external debug link and the core debug block.

Parameters:
P_RESP_TIMEOUT, 1024, cycles waited in WAIT_RESP before a timeout response is generated (must be >=2)
P_TIMEOUT_W, 11, width of the timeout counter (must satisfy 2^P_TIMEOUT_W > P_RESP_TIMEOUT)

Ports:
iCLOCK  in  1  clock; all logic on rising edge
iRESET_SYNC  in  1  reset, synchronous, active-high
iRX_VALID  in  1  inbound byte valid
iRX_DATA  in  8  inbound byte
oRX_BUSY  out  1  byte not accepted this cycle
oCMD_REQ  out  1  command request to debug block
iCMD_BUSY  in  1  debug block busy
oCMD_COMMAND  out  4  command code
oCMD_TARGET  out  8  register target
oCMD_DATA  out  32  command data
iRESP_VALID  in  1  response pulse, 1 cycle
iRESP_ERROR  in  1  response error flag
iRESP_DATA  in  32  response data
oTX_VALID  out  1  outbound byte valid
oTX_DATA  out  8  outbound byte
iTX_BUSY  in  1  transmitter busy
oERR_FRAME  out  1  1-cycle pulse: bad header byte dropped
oIDLE  out  1  state == RX_HDR

Behaviour:
- Reset (iRESET_SYNC=1 at a clock edge): state RX_HDR. All outputs 0 except oIDLE=1. Byte index, timeout counter, and captured fields cleared. Reset mid-frame aborts any RX, CMD, wait, or TX activity with no further bytes emitted.
- Command frame, big-endian: B0={4'hA, cmd[3:0]}, B1=target, B2..B5=data[31:24]..data[7:0].
- Response frame: B0={4'h5, 2'b00, timeout, error}, B1..B4=data[31:24]..data[7:0].
- RX byte accepted when iRX_VALID && !oRX_BUSY. oRX_BUSY=0 only in RX_HDR/RX_BODY. Bytes offered while busy are ignored; the source must hold them.
- RX_HDR: on an accepted byte with upper nibble 4'hA, latch cmd, set index=1, go to RX_BODY. Any other accepted byte is dropped; oERR_FRAME=1 next cycle; stay in RX_HDR.
- RX_BODY: latch bytes 1..5 into target/data. Accepting index 5 moves to ISSUE. No inter-byte timeout.
- ISSUE: oCMD_REQ=1, COMMAND/TARGET/DATA stable. Entered the cycle after the last RX byte is accepted. The command is accepted in the cycle oCMD_REQ && !iCMD_BUSY. The next cycle drops oCMD_REQ and moves to WAIT_RESP with counter=0. REQ is held indefinitely while BUSY.
- WAIT_RESP: counter increments each cycle. If iRESP_VALID: capture error/data, timeout=0, go to TX. Else if counter==P_RESP_TIMEOUT-1: timeout=1, error=0, data=0, go to TX. If both happen in the same cycle, the response wins.
- iRESP_VALID in any state other than WAIT_RESP, including the ISSUE accept cycle, is ignored.
- TX: oTX_VALID=1 with byte[index] from the cycle after capture. A byte transfers when oTX_VALID && !iTX_BUSY. The next byte is presented the following cycle. After B4 transfers, oTX_VALID=0 and the state returns to RX_HDR the next cycle.
- Minimum turnaround with BUSY/TX_BUSY low: last RX byte at N, REQ at N+1, WAIT_RESP at N+2. Response at M gives TX B0 at M+1 and B4 at M+5.
- Codes: READ_REG=0, WRITE_REG=1, GO=8, INTGO=9, STEP=A, STOP=F. The bridge does not decode them; every frame is forwarded. Commands the debug block does not answer end in a timeout response.
- Counter width: counter saturates. It is never compared beyond P_RESP_TIMEOUT-1.

Decomposition:
- Shared include core_debug_host.h holds:
  - frame header nibbles (CMD 4'hA, RESP 4'h5);
  - debug command codes and register target codes, shared with the debug block;
  - state encodings (RX_HDR, RX_BODY, ISSUE, WAIT_RESP, TX);
  - frame lengths (6, 5).
- One natural sub-module, core_debug_host_tx_ser: loads 40 bits {status, data} and shifts out 5 bytes under the VALID/BUSY rule.

Test Plan:
- Frame A0 40 00 00 00 00 (READ_REG, target CPUIDR) with BUSY=0:
  - expect REQ for 1 cycle, COMMAND=0, TARGET=0x40, DATA=0.
  - inject RESP_VALID, DATA=0x12345678 two cycles later; expect TX 50 12 34 56 78.
- Frame AF 00 00 00 00 00 with iCMD_BUSY=1 for 7 cycles: REQ held 8 cycles, fields stable; accepted on cycle 8; response ACK gives TX 50 00 00 00 00.
- Frame A1 05 DE AD BE EF with no response, P_RESP_TIMEOUT=16: TX 52 00 00 00 00 exactly 16 cycles after entering WAIT_RESP.
- RESP_VALID on the timeout terminal cycle with ERROR=1, DATA=0xCAFEF00D: TX 51 CA FE F0 0D, timeout bit 0.
- Bytes 3C, 00 then A8 ...: two oERR_FRAME pulses, then the valid GO frame is issued normally. iTX_BUSY toggled every other cycle: each byte held until its transfer, no byte lost or duplicated.
- iRESET_SYNC during the TX of B2: oTX_VALID=0 the next cycle, oIDLE=1. A new frame is then processed correctly.
